fifo_flags: RTL and testbench

- Single-clock synchronous FIFO for one TLP lane, with occupancy-flag generation.
- Four instances sit directly upstream of the flow-control FSM.
- Each instance drives one FIFOpauseN (almost-full), one FIFOcontinueN (almost-empty) and one overflow indication into the FSM.
- Thresholds are runtime inputs so the FSM/config logic can set them during init.

---
 rtl/fifo_flags_pkg.sv | 14 +
 rtl/fifo_flags_mem_dp.sv | 42 ++++
 rtl/fifo_flags.sv | 99 +++++++++
 tb/tb_fifo_flags.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flags_pkg.sv
// Shared constants for the per-lane TLP FIFOs feeding the flow-control FSM.
package fifo_flags_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 10;
  localparam int unsigned ADDR_WIDTH_DEF = 3;

  // One FIFO per TLP lane in front of the flow-control FSM.
  localparam int unsigned NUM_LANES = 4;

  // Power-on thresholds the config logic starts from.
  localparam int unsigned THR_HIGH_DEF = 6;
  localparam int unsigned THR_LOW_DEF  = 1;

endpackage

// File: rtl/fifo_flags_mem_dp.sv
// Simple dual-port register array: synchronous write, registered synchronous read.
module fifo_flags_mem_dp
  import fifo_flags_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Array write; contents deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register; holds its last value when no read is issued.
  // Same-address read/write returns the old word, which is what a full FIFO needs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_flags.sv
// Single-clock lane FIFO with occupancy flags and dropped-request pulses.
module fifo_flags
  import fifo_flags_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH:0]   i_thr_high,
  input  logic [ADDR_WIDTH:0]   i_thr_low,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_valid_out,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned         DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count, w_count_d;
  logic                  r_valid, r_overflow, r_underflow;
  logic                  w_wr_acc, w_rd_acc;
  logic                  w_empty, w_full;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == DEPTH_C);
  // No write-to-read bypass: an empty FIFO never accepts a read.
  assign w_rd_acc = i_rd_en & ~w_empty;
  // A full FIFO takes a write only when a read frees a slot on the same edge.
  assign w_wr_acc = i_wr_en & (~w_full | w_rd_acc);

  // Occupancy next-state: simultaneous accepted read and write cancel out.
  always_comb begin
    w_count_d = r_count;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_d = r_count + 1'b1;
      2'b01:   w_count_d = r_count - 1'b1;
      default: w_count_d = r_count;
    endcase
  end

  // Pointers, count, read-valid and one-cycle error pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= w_count_d;
      r_valid     <= w_rd_acc;
      r_overflow  <= i_wr_en & ~w_wr_acc;
      r_underflow <= i_rd_en & w_empty;
    end
  end

  fifo_flags_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_data_in),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (o_data_out)
  );

  // Flags are combinational from the count so they track it with no extra latency;
  // out-of-range thresholds fall out of the plain comparisons.
  always_comb begin
    o_empty        = w_empty;
    o_full         = w_full;
    o_almost_full  = (r_count >= i_thr_high);
    o_almost_empty = (r_count <= i_thr_low);
  end

  assign o_count     = r_count;
  assign o_valid_out = r_valid;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_fifo_flags.sv
// Randomised and directed bench for fifo_flags against a queue-based reference model.
module tb_fifo_flags;

  localparam int unsigned DW    = 10;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en;
  logic [DW-1:0] data_in;
  logic [AW:0]   thr_high, thr_low;
  logic [DW-1:0] data_out;
  logic          valid_out, empty, full, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  fifo_flags #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_wr_en        (wr_en),
    .i_data_in      (data_in),
    .i_rd_en        (rd_en),
    .i_thr_high     (thr_high),
    .i_thr_low      (thr_low),
    .o_data_out     (data_out),
    .o_valid_out    (valid_out),
    .o_count        (count),
    .o_empty        (empty),
    .o_full         (full),
    .o_almost_full  (almost_full),
    .o_almost_empty (almost_empty),
    .o_overflow     (overflow),
    .o_underflow    (underflow)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout = '0;
  logic          exp_valid = 1'b0;
  logic          exp_ovf = 1'b0;
  logic          exp_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_flags();
    int n;
    n = q.size();
    check("count", 32'(count), 32'(n));
    check("empty", 32'(empty), 32'(n == 0));
    check("full", 32'(full), 32'(n == DEPTH));
    check("almost_full", 32'(almost_full), 32'(n >= int'(thr_high)));
    check("almost_empty", 32'(almost_empty), 32'(n <= int'(thr_low)));
  endtask

  task automatic check_all();
    check_flags();
    check("valid_out", 32'(valid_out), 32'(exp_valid));
    check("data_out", 32'(data_out), 32'(exp_dout));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_unf));
  endtask

  // One clock of stimulus; called 1 time unit after a rising edge.
  task automatic step(input logic wr, input logic [DW-1:0] din, input logic rd);
    bit model_full, model_empty, racc, wacc;
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    @(posedge clk);
    model_full  = (q.size() == DEPTH);
    model_empty = (q.size() == 0);
    racc = rd && !model_empty;
    wacc = wr && (!model_full || racc);
    exp_ovf = wr && !wacc;
    exp_unf = rd && model_empty;
    exp_valid = racc;
    if (racc) exp_dout = q.pop_front();
    if (wacc) q.push_back(din);
    #1;
    check_all();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  // Runaway guard.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    data_in  = '0;
    thr_high = 4'd6;
    thr_low  = 4'd1;
    #3;
    check_all();
    thr_high = 4'd0;
    #1;
    check("af_thr0_in_reset", 32'(almost_full), 32'd1);
    thr_high = 4'd6;
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Fill with 0x001..0x008; flags follow the model each cycle.
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0);
    check("full_after_fill", 32'(full), 32'd1);

    // Threshold corner cases applied combinationally on a full FIFO.
    thr_high = 4'd9;
    #1 check("af_thr_above_depth", 32'(almost_full), 32'd0);
    thr_high = 4'd8;
    #1 check("af_thr_eq_depth", 32'(almost_full), 32'd1);
    thr_low = 4'd8;
    #1 check("ae_thr_eq_depth", 32'(almost_empty), 32'd1);
    thr_high = 4'd6;
    thr_low  = 4'd1;

    // Write while full is dropped.
    step(1'b1, 10'h3FF, 1'b0);
    check("ovf_pulse", 32'(overflow), 32'd1);
    step(1'b0, '0, 1'b0);
    check("ovf_one_cycle", 32'(overflow), 32'd0);

    // Simultaneous write+read when full.
    step(1'b1, 10'h123, 1'b1);
    check("full_rw_oldest", 32'(data_out), 32'h001);

    // Drain; the model checks order and absence of 0x3FF.
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    check("drain_last_new", 32'(data_out), 32'h123);

    // Empty FIFO, read and write together: only the write lands.
    step(1'b1, 10'h055, 1'b1);
    check("empty_rw_unf", 32'(underflow), 32'd1);
    step(1'b0, '0, 1'b1);
    check("empty_rw_readback", 32'(data_out), 32'h055);

    // 20 words streamed with overlapping write/read; pointers wrap.
    step(1'b1, 10'h100, 1'b0);
    for (int i = 1; i < 20; i++) step(1'b1, DW'(10'h100 + i), 1'b1);
    step(1'b0, '0, 1'b1);

    // Random traffic and thresholds.
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) begin
        thr_high = 4'($urandom_range(0, 15));
        thr_low  = 4'($urandom_range(0, 15));
      end
      step(1'($urandom_range(0, 3) != 0 ? (i % 64 < 32) : $urandom_range(0, 1)),
           DW'($urandom), 1'($urandom_range(0, 3) != 0 ? (i % 64 >= 32) : $urandom_range(0, 1)));
    end
    thr_high = 4'd6;
    thr_low  = 4'd1;

    // Mid-stream asynchronous reset at count 5.
    while (q.size() > 0) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, DW'(10'h200 + i), 1'b0);
    check("count5_before_reset", 32'(count), 32'd5);
    step(1'b0, '0, 1'b1);
    step(1'b1, 10'h205, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_count", 32'(count), 32'd0);
    check("async_empty", 32'(empty), 32'd1);
    check("async_valid", 32'(valid_out), 32'd0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    step(1'b1, 10'h2AA, 1'b0);
    step(1'b0, '0, 1'b1);
    check("post_reset_roundtrip", 32'(data_out), 32'h2AA);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
